weighted_rr_arbiter: RTL and testbench



---
 rtl/weighted_rr_arbiter_pkg.sv | 22 ++
 rtl/weighted_rr_arbiter_if.sv | 27 ++
 rtl/weighted_rr_arbiter_rr_pick.sv | 20 ++
 rtl/weighted_rr_arbiter.sv | 104 ++++++++++
 tb/tb_weighted_rr_arbiter.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/weighted_rr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package weighted_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int MAX_INPUTS = 32;
  localparam int MAX_ID_W   = 5;

  // Binary index of a one-hot vector; zero input maps to zero.
  function automatic logic [MAX_ID_W-1:0] onehot2bin(input logic [MAX_INPUTS-1:0] oh);
    logic [MAX_ID_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < MAX_INPUTS; i++) begin
      if (oh[i]) bin |= MAX_ID_W'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/weighted_rr_arbiter_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
interface weighted_rr_arbiter_if #(
  parameter int NUM_INPUTS = 4,
  parameter int WEIGHT_W   = 4
);
  localparam int ID_W = $clog2(NUM_INPUTS);

  logic [NUM_INPUTS-1:0]          req;
  logic [NUM_INPUTS-1:0]          priv;
  logic [NUM_INPUTS*WEIGHT_W-1:0] weight;
  logic                           ready;
  logic [NUM_INPUTS-1:0]          grant;
  logic                           grant_vld;
  logic [ID_W-1:0]                grant_id;
  logic [WEIGHT_W-1:0]            credit_left;

  modport master (
    output req, priv, weight, ready,
    input  grant, grant_vld, grant_id, credit_left
  );

  modport slave (
    input  req, priv, weight, ready,
    output grant, grant_vld, grant_id, credit_left
  );

endinterface

// File: rtl/weighted_rr_arbiter_rr_pick.sv
// Rotating find-first: first set bit of req_i at or above the one-hot ptr_i, with wrap.
module arb_rr_pick #(
  parameter int NUM_INPUTS = 4
) (
  input  logic [NUM_INPUTS-1:0] req_i,
  input  logic [NUM_INPUTS-1:0] ptr_i,
  output logic [NUM_INPUTS-1:0] gnt_o,
  output logic                  vld_o
);

  logic [2*NUM_INPUTS-1:0] dbl_req;
  logic [2*NUM_INPUTS-1:0] dbl_gnt;

  // The borrow stops at the first request at/above ptr, or runs into the upper copy to wrap.
  assign dbl_req = {req_i, req_i};
  assign dbl_gnt = dbl_req & ~(dbl_req - {{NUM_INPUTS{1'b0}}, ptr_i});
  assign gnt_o   = dbl_gnt[NUM_INPUTS-1:0] | dbl_gnt[2*NUM_INPUTS-1:NUM_INPUTS];
  assign vld_o   = |req_i;

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: registered grants held for up to weight beats,
// with privileged requests able to cut a non-privileged burst at a beat boundary.
module weighted_rr_arbiter
  import weighted_arb_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int WEIGHT_W   = 4
) (
  input logic                 clk,
  input logic                 reset,
  weighted_rr_arbiter_if.slave bus
);

  localparam int ID_W = $clog2(NUM_INPUTS);

  arb_state_e              state_q, state_d;
  logic [NUM_INPUTS-1:0]   grant_q, grant_d;
  logic [NUM_INPUTS-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [WEIGHT_W-1:0]     credit_q, credit_d;

  logic                    beat, owner_req, owner_priv, other_priv, release_now;
  logic [NUM_INPUTS-1:0]   ptr_next, pick_ptr;
  logic [NUM_INPUTS-1:0]   priv_win, req_win, win;
  logic                    priv_vld, req_vld;
  logic [ID_W-1:0]         win_id;
  logic [WEIGHT_W-1:0]     win_weight;

  assign beat        = (state_q == BUSY) && bus.ready;
  assign owner_req   = |(bus.req & grant_q);
  assign owner_priv  = |(bus.priv & grant_q);
  assign other_priv  = |(bus.req & bus.priv & ~grant_q);
  assign release_now = (state_q == BUSY) &&
                       (!owner_req ||
                        (beat && credit_q == WEIGHT_W'(1)) ||
                        (beat && other_priv && !owner_priv));

  // The pointer is kept one-hot, so "owner + 1 mod N" is a rotate of the grant.
  assign ptr_next = {grant_q[NUM_INPUTS-2:0], grant_q[NUM_INPUTS-1]};
  assign pick_ptr = release_now ? ptr_next : ptr_q;

  arb_rr_pick #(.NUM_INPUTS(NUM_INPUTS)) u_pick_priv (
    .req_i (bus.req & bus.priv),
    .ptr_i (pick_ptr),
    .gnt_o (priv_win),
    .vld_o (priv_vld)
  );

  arb_rr_pick #(.NUM_INPUTS(NUM_INPUTS)) u_pick_req (
    .req_i (bus.req),
    .ptr_i (pick_ptr),
    .gnt_o (req_win),
    .vld_o (req_vld)
  );

  assign win        = priv_vld ? priv_win : req_win;
  assign win_id     = ID_W'(onehot2bin(MAX_INPUTS'(win)));
  assign win_weight = bus.weight[win_id*WEIGHT_W +: WEIGHT_W];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    credit_d = credit_q;
    if (state_q == BUSY && release_now) begin
      ptr_d    = ptr_next;
      state_d  = IDLE;
      grant_d  = '0;
      credit_d = '0;
    end else if (state_q == BUSY && beat) begin
      credit_d = credit_q - WEIGHT_W'(1);
    end
    // A fresh grant loads from IDLE or directly on release, so there is no idle bubble.
    if ((state_q == IDLE || release_now) && req_vld) begin
      state_d  = BUSY;
      grant_d  = win;
      id_d     = win_id;
      credit_d = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= NUM_INPUTS'(1);
      id_q     <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      credit_q <= credit_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_vld   = (state_q == BUSY);
  assign bus.grant_id    = id_q;
  assign bus.credit_left = credit_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed bench for weighted_rr_arbiter: expected outputs are queued per step
// and checked one cycle later with immediate assertions.
module tb_weighted_rr_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic       vld;
    logic [1:0] id;
    logic [3:0] credit;
  } exp_t;

  exp_t sb[$];

  weighted_rr_arbiter_if #(.NUM_INPUTS(4), .WEIGHT_W(4)) bus ();

  weighted_rr_arbiter #(.NUM_INPUTS(4), .WEIGHT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] priv, input logic ready);
    bus.req   = req;
    bus.priv  = priv;
    bus.ready = ready;
  endtask

  task automatic setWeights(input logic [3:0] w0, input logic [3:0] w1,
                            input logic [3:0] w2, input logic [3:0] w3);
    bus.weight = {w3, w2, w1, w0};
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [10:0] obs, expv;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=%0d expected=1", sb.size());
    end else begin
      e    = sb.pop_front();
      obs  = {bus.grant, bus.grant_vld, bus.grant_id, bus.credit_left};
      expv = {e.grant, e.vld, e.id, e.credit};
      assert (obs === expv) else begin
        failures++;
        $error("[TB] FAIL %s observed grant=%b vld=%b id=%0d credit=%0d expected grant=%b vld=%b id=%0d credit=%0d",
               e.tag, bus.grant, bus.grant_vld, bus.grant_id, bus.credit_left,
               e.grant, e.vld, e.id, e.credit);
      end
    end
  endtask

  // Queue the expectation for the coming edge, then check just after it.
  task automatic step(input string tag, input logic [3:0] g, input logic [1:0] id, input logic [3:0] c);
    exp_t e;
    e.tag = tag; e.grant = g; e.vld = |g; e.id = id; e.credit = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    step(tag, 4'b0000, 2'd0, 4'd0);
    reset = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    setWeights(4'd0, 4'd0, 4'd0, 4'd0);
    doReset("reset_a");

    // All four requesting, weight 2 each: two-cycle grants rotating 0..3 with no gaps.
    setWeights(4'd2, 4'd2, 4'd2, 4'd2);
    applyStimulus(4'b1111, 4'b0000, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step($sformatf("rr_%0d", k), 4'(1 << ((k / 2) % 4)), 2'((k / 2) % 4), 4'(2 - (k % 2)));
    end

    // Sole requester with weight 0 gets one-beat grants back to back.
    doReset("reset_b");
    setWeights(4'd2, 4'd2, 4'd0, 4'd2);
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step($sformatf("sole_%0d", k), 4'b0100, 2'd2, 4'd1);
    end

    // Stalled burst holds credit; a weight change mid-burst only affects the next grant.
    doReset("reset_c");
    setWeights(4'd2, 4'd5, 4'd2, 4'd2);
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    step("c_grant", 4'b0010, 2'd1, 4'd5);
    setWeights(4'd2, 4'd9, 4'd2, 4'd2);
    for (int k = 0; k < 3; k++) begin
      step($sformatf("c_hold_%0d", k), 4'b0010, 2'd1, 4'd5);
    end
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step($sformatf("c_count_%0d", k), 4'b0010, 2'd1, 4'(4 - k));
    end
    step("c_regrant", 4'b0010, 2'd1, 4'd9);
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    step("c_idle", 4'b0000, 2'd1, 4'd0);

    // Privileged request preempts only on an accepted beat; a privileged owner is not preempted.
    doReset("reset_d");
    setWeights(4'd5, 4'd2, 4'd2, 4'd2);
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    step("d_grant", 4'b0001, 2'd0, 4'd5);
    applyStimulus(4'b0001, 4'b0000, 1'b1);
    step("d_beat4", 4'b0001, 2'd0, 4'd4);
    step("d_beat3", 4'b0001, 2'd0, 4'd3);
    applyStimulus(4'b1001, 4'b1000, 1'b0);
    step("d_nobeat", 4'b0001, 2'd0, 4'd3);
    applyStimulus(4'b1001, 4'b1000, 1'b1);
    step("d_preempt", 4'b1000, 2'd3, 4'd2);
    applyStimulus(4'b1001, 4'b1001, 1'b1);
    step("d_privhold", 4'b1000, 2'd3, 4'd1);
    step("d_privdone", 4'b0001, 2'd0, 4'd5);

    // Owner dropping req releases immediately; with no other requester the grant goes idle.
    doReset("reset_e");
    setWeights(4'd2, 4'd2, 4'd4, 4'd3);
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    step("e_grant", 4'b0100, 2'd2, 4'd4);
    step("e_beat", 4'b0100, 2'd2, 4'd3);
    applyStimulus(4'b1000, 4'b0000, 1'b1);
    step("e_drop", 4'b1000, 2'd3, 4'd3);
    applyStimulus(4'b0000, 4'b0000, 1'b1);
    step("e_idle", 4'b0000, 2'd3, 4'd0);

    // Reset mid-burst clears state and pointer; arbitration restarts from index 0.
    doReset("reset_f0");
    setWeights(4'd2, 4'd3, 4'd1, 4'd2);
    applyStimulus(4'b0100, 4'b0000, 1'b1);
    step("f_grant", 4'b0100, 2'd2, 4'd1);
    applyStimulus(4'b0010, 4'b0000, 1'b1);
    step("f_switch", 4'b0010, 2'd1, 4'd3);
    step("f_beat", 4'b0010, 2'd1, 4'd2);
    reset = 1'b1;
    step("f_reset", 4'b0000, 2'd0, 4'd0);
    reset = 1'b0;
    applyStimulus(4'b1010, 4'b0000, 1'b1);
    step("f_ptr0", 4'b0010, 2'd1, 4'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
